// File: rtl/priority_decoder_if.sv
// Bus bundle between the bit-scan encoder side and priority_decoder.
// The master drives the one-hot masks; the slave (decoder) returns indices, span and status.
interface priority_decoder_if #(
  parameter int WIDTH  = 50,
  parameter int ERR_CW = 16
);
  localparam int IDX_W  = $clog2(WIDTH);
  localparam int SPAN_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  data_left_i;
  logic [WIDTH-1:0]  data_right_i;
  logic              data_val_i;
  logic [IDX_W-1:0]  idx_left_o;
  logic [IDX_W-1:0]  idx_right_o;
  logic [SPAN_W-1:0] span_o;
  logic              empty_o;
  logic              err_o;
  logic              data_val_o;
  logic [ERR_CW-1:0] err_cnt_o;

  modport master (
    output data_left_i, data_right_i, data_val_i,
    input  idx_left_o, idx_right_o, span_o, empty_o, err_o, data_val_o, err_cnt_o
  );

  modport slave (
    input  data_left_i, data_right_i, data_val_i,
    output idx_left_o, idx_right_o, span_o, empty_o, err_o, data_val_o, err_cnt_o
  );
endinterface

// File: rtl/priority_decoder.sv
// Two-stage decoder turning leftmost/rightmost one-hot masks back into binary indices
// and span, with malformed-word detection and a saturating error counter.
module priority_decoder #(
  parameter int WIDTH  = 50,
  parameter int IDX_W  = $clog2(WIDTH),
  parameter int SPAN_W = $clog2(WIDTH + 1),
  parameter int ERR_CW = 16
) (
  input logic               clk_i,
  input logic               arst_n_i,
  priority_decoder_if.slave bus
);

  logic [IDX_W-1:0]  w_idx_left;
  logic [IDX_W-1:0]  w_idx_right;

  logic              r_s1_val;
  logic [IDX_W-1:0]  r_s1_idx_left;
  logic [IDX_W-1:0]  r_s1_idx_right;
  logic              r_s1_oh_left;
  logic              r_s1_oh_right;
  logic              r_s1_zero_left;
  logic              r_s1_zero_right;

  logic              w_empty;
  logic              w_err;
  logic [IDX_W-1:0]  w_out_left;
  logic [IDX_W-1:0]  w_out_right;
  logic [SPAN_W-1:0] w_span;

  logic              r_val;
  logic [IDX_W-1:0]  r_idx_left;
  logic [IDX_W-1:0]  r_idx_right;
  logic [SPAN_W-1:0] r_span;
  logic              r_empty;
  logic              r_err;
  logic [ERR_CW-1:0] r_err_cnt;

  // OR of set-bit positions: exact for one-hot masks, don't-care otherwise
  always_comb begin
    w_idx_left  = '0;
    w_idx_right = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.data_left_i[i])  w_idx_left  |= IDX_W'(i);
      if (bus.data_right_i[i]) w_idx_right |= IDX_W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_s1_val        <= 1'b0;
      r_s1_idx_left   <= '0;
      r_s1_idx_right  <= '0;
      r_s1_oh_left    <= 1'b0;
      r_s1_oh_right   <= 1'b0;
      r_s1_zero_left  <= 1'b0;
      r_s1_zero_right <= 1'b0;
    end else begin
      r_s1_val <= bus.data_val_i;
      if (bus.data_val_i) begin
        r_s1_idx_left   <= w_idx_left;
        r_s1_idx_right  <= w_idx_right;
        r_s1_oh_left    <= $onehot(bus.data_left_i);
        r_s1_oh_right   <= $onehot(bus.data_right_i);
        r_s1_zero_left  <= ~|bus.data_left_i;
        r_s1_zero_right <= ~|bus.data_right_i;
      end
    end
  end

  // A lone zero mask is not one-hot, so it falls into the malformed branch
  always_comb begin
    w_empty     = 1'b0;
    w_err       = 1'b0;
    w_out_left  = '0;
    w_out_right = '0;
    w_span      = '0;
    if (r_s1_zero_left && r_s1_zero_right) begin
      w_empty = 1'b1;
    end else if (!r_s1_oh_left || !r_s1_oh_right || (r_s1_idx_left < r_s1_idx_right)) begin
      w_err = 1'b1;
    end else begin
      w_out_left  = r_s1_idx_left;
      w_out_right = r_s1_idx_right;
      w_span      = SPAN_W'(r_s1_idx_left) - SPAN_W'(r_s1_idx_right) + SPAN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_val       <= 1'b0;
      r_idx_left  <= '0;
      r_idx_right <= '0;
      r_span      <= '0;
      r_empty     <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_val <= r_s1_val;
      if (r_s1_val) begin
        r_idx_left  <= w_out_left;
        r_idx_right <= w_out_right;
        r_span      <= w_span;
        r_empty     <= w_empty;
        r_err       <= w_err;
        if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_CW'(1);
      end
    end
  end

  assign bus.data_val_o  = r_val;
  assign bus.idx_left_o  = r_idx_left;
  assign bus.idx_right_o = r_idx_right;
  assign bus.span_o      = r_span;
  assign bus.empty_o     = r_empty;
  assign bus.err_o       = r_err;
  assign bus.err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder: a full-width-counter instance plus an ERR_CW=4
// instance sharing the same stimulus so counter saturation is visible.
module tb_priority_decoder;

  localparam int WIDTH = 50;

  typedef struct {
    logic [5:0]  idxL;
    logic [5:0]  idxR;
    logic [5:0]  span;
    logic        empty;
    logic        err;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    int          due;
  } expT;

  logic clk_i = 1'b0;
  logic arst_n_i;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  expT         sb[$];
  expT         held;
  logic [15:0] modelCnt;
  logic [3:0]  modelCnt4;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  priority_decoder_if #(.WIDTH(WIDTH), .ERR_CW(16)) busMain ();
  priority_decoder_if #(.WIDTH(WIDTH), .ERR_CW(4))  busSat ();

  priority_decoder #(.WIDTH(WIDTH), .ERR_CW(16)) u_dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .bus(busMain)
  );

  priority_decoder #(.WIDTH(WIDTH), .ERR_CW(4)) u_sat (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .bus(busSat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] oneHot(input int pos);
    logic [WIDTH-1:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  // Reference classification built from bit counts and positions
  function automatic expT model(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    expT e;
    int  li, ri;
    e = '{default: '0};
    li = 0;
    ri = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (l[i]) li = i;
      if (r[i]) ri = i;
    end
    if (l == '0 && r == '0) e.empty = 1'b1;
    else if ($countones(l) != 1 || $countones(r) != 1) e.err = 1'b1;
    else if (li < ri) e.err = 1'b1;
    else begin
      e.idxL = 6'(li);
      e.idxR = 6'(ri);
      e.span = 6'(li - ri + 1);
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r, input logic v);
    expT e;
    busMain.data_left_i  = l;
    busMain.data_right_i = r;
    busMain.data_val_i   = v;
    busSat.data_left_i   = l;
    busSat.data_right_i  = r;
    busSat.data_val_i    = v;
    if (v) begin
      e = model(l, r);
      if (e.err) begin
        if (modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
        if (modelCnt4 != 4'hF) modelCnt4 = modelCnt4 + 4'd1;
      end
      e.cnt  = modelCnt;
      e.cnt4 = modelCnt4;
      e.due  = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput();
    expT e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("val_o", 64'(busMain.data_val_o), 64'd1);
      check("idx_left", 64'(busMain.idx_left_o), 64'(e.idxL));
      check("idx_right", 64'(busMain.idx_right_o), 64'(e.idxR));
      check("span", 64'(busMain.span_o), 64'(e.span));
      check("empty", 64'(busMain.empty_o), 64'(e.empty));
      check("err", 64'(busMain.err_o), 64'(e.err));
      check("err_cnt", 64'(busMain.err_cnt_o), 64'(e.cnt));
      check("sat_val_o", 64'(busSat.data_val_o), 64'd1);
      check("sat_err_cnt", 64'(busSat.err_cnt_o), 64'(e.cnt4));
      held = e;
    end else begin
      check("idle_val_o", 64'(busMain.data_val_o), 64'd0);
      check("hold_idx_left", 64'(busMain.idx_left_o), 64'(held.idxL));
      check("hold_idx_right", 64'(busMain.idx_right_o), 64'(held.idxR));
      check("hold_span", 64'(busMain.span_o), 64'(held.span));
      check("hold_empty", 64'(busMain.empty_o), 64'(held.empty));
      check("hold_err_cnt", 64'(busMain.err_cnt_o), 64'(held.cnt));
      check("hold_sat_err_cnt", 64'(busSat.err_cnt_o), 64'(held.cnt4));
    end
  endtask

  task automatic step(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r, input logic v);
    @(negedge clk_i);
    checkOutput();
    applyStimulus(l, r, v);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_val_o"}, 64'(busMain.data_val_o), 64'd0);
    check({tag, "_idx_left"}, 64'(busMain.idx_left_o), 64'd0);
    check({tag, "_idx_right"}, 64'(busMain.idx_right_o), 64'd0);
    check({tag, "_span"}, 64'(busMain.span_o), 64'd0);
    check({tag, "_empty"}, 64'(busMain.empty_o), 64'd0);
    check({tag, "_err"}, 64'(busMain.err_o), 64'd0);
    check({tag, "_err_cnt"}, 64'(busMain.err_cnt_o), 64'd0);
    check({tag, "_sat_err_cnt"}, 64'(busSat.err_cnt_o), 64'd0);
  endtask

  task automatic clearModel();
    sb.delete();
    held      = '{default: '0};
    modelCnt  = '0;
    modelCnt4 = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] l, r;
    int li, ri;

    clearModel();
    arst_n_i = 1'b0;
    applyStimulus('0, '0, 1'b0);
    #1;
    checkAllZero("reset");
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;

    $display("[TB] directed words");
    step(oneHot(37), oneHot(4), 1'b1);
    step(oneHot(49), oneHot(0), 1'b1);
    step(oneHot(12), oneHot(12), 1'b1);
    step('0, '0, 1'b1);
    l = '0;
    l[1:0] = 2'b11;
    step(l, oneHot(0), 1'b1);
    step('0, '0, 1'b0);
    step(oneHot(2), oneHot(9), 1'b1);
    step(oneHot(5), '0, 1'b1);
    repeat (4) step('0, '0, 1'b0);

    $display("[TB] reset with words in flight");
    step(oneHot(20), oneHot(3), 1'b1);
    step(oneHot(30), oneHot(1), 1'b1);
    #2;
    arst_n_i = 1'b0;
    #1;
    checkAllZero("midreset");
    clearModel();
    applyStimulus('0, '0, 1'b0);
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    repeat (4) step('0, '0, 1'b0);

    $display("[TB] streaming random legal words");
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        step('0, '0, 1'b1);
      end else begin
        ri = $urandom_range(0, WIDTH - 1);
        li = $urandom_range(ri, WIDTH - 1);
        step(oneHot(li), oneHot(ri), 1'b1);
      end
    end
    repeat (3) step('0, '0, 1'b0);

    $display("[TB] error counter saturation");
    for (int n = 0; n < 20; n++) begin
      case (n % 3)
        0: step(oneHot(3), oneHot(40), 1'b1);
        1: step('0, oneHot(7), 1'b1);
        default: begin
          l = '0;
          l[10] = 1'b1;
          l[20] = 1'b1;
          step(l, oneHot(1), 1'b1);
        end
      endcase
      if (n % 4 == 0) step('0, '0, 1'b0);
    end
    repeat (4) step('0, '0, 1'b0);

    check("sat_final_cnt", 64'(busSat.err_cnt_o), 64'd15);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
